// File: rtl/fall_pkg.sv
// fall_pkg: shared types and default parameters for the fall_monitor slice.
//   fd_state_e - per-lane detector state (2-bit encoding)
//   FD_*_DEF   - default parameter values used by fall_monitor / fall_channel
package fall_pkg;

    typedef enum logic [1:0] {
        FD_IDLE    = 2'd0,
        FD_PENDING = 2'd1,
        FD_ALARM   = 2'd2
    } fd_state_e;

    localparam int FD_WIDTH_DEF    = 8;
    localparam int FD_CHANNELS_DEF = 4;
    localparam int FD_HOLD_DEF     = 3;
    localparam int FD_CNT_W_DEF    = 8;
    localparam int FD_HYST_DEF     = 2;

endpackage

// File: rtl/fall_channel.sv
// fall_channel: one sensor lane of fall_monitor.
// A sample qualifies when valid and sensor < factory (unsigned, strict).
// HOLD consecutive qualifying samples latch an alarm until an ack arrives
// while the release condition holds. Each alarm entry bumps a saturating
// event counter; clr_count zeroes it and wins over a same-cycle increment.
// Optional macro FALL_HYST_EN: release needs sensor >= factory + HYST
// (computed at WIDTH+1 bits); otherwise release needs sensor >= factory.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   sample_valid          sample strobe
//   sensor, factory       lane value and threshold
//   ack                   alarm acknowledge
//   clr_count             synchronous counter clear
//   fall_pending          registered: in FD_PENDING
//   fall_detected         registered: in FD_ALARM
//   fall_count            registered saturating event count
module fall_channel
    import fall_pkg::*;
#(
    parameter int WIDTH = FD_WIDTH_DEF,
    parameter int HOLD  = FD_HOLD_DEF,
    parameter int CNT_W = FD_CNT_W_DEF,
    parameter int HYST  = FD_HYST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sensor,
    input  logic [WIDTH-1:0] factory,
    input  logic             ack,
    input  logic             clr_count,
    output logic             fall_pending,
    output logic             fall_detected,
    output logic [CNT_W-1:0] fall_count
);

    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);
`ifdef FALL_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    localparam int HYST_EFF = 0;
`endif
    localparam logic [WIDTH:0] HYST_X = (WIDTH + 1)'(HYST_EFF);

    fd_state_e        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             det_q, det_d;
    logic             qual, release_ok, enter_alarm;

    assign qual    = sample_valid && (sensor < factory);
    assign run_inc = run_q + RUN_W'(1);
    // Widened sum: a threshold+margin that overflows WIDTH can never release.
    assign release_ok = {1'b0, sensor} >= ({1'b0, factory} + HYST_X);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        enter_alarm = 1'b0;
        case (state_q)
            FD_IDLE, FD_PENDING: begin
                // IDLE has run=0, so the same increment path covers HOLD=1.
                if (qual) begin
                    run_d = run_inc;
                    if (run_inc == HOLD_R) begin
                        state_d     = FD_ALARM;
                        enter_alarm = 1'b1;
                    end else begin
                        state_d = FD_PENDING;
                    end
                end else if (sample_valid) begin
                    state_d = FD_IDLE;
                    run_d   = '0;
                end
            end
            FD_ALARM: begin
                if (ack && release_ok) begin
                    state_d = FD_IDLE;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = FD_IDLE;
                run_d   = '0;
            end
        endcase

        pend_d = (state_d == FD_PENDING);
        det_d  = (state_d == FD_ALARM);

        cnt_d = cnt_q;
        if (clr_count)
            cnt_d = '0;
        else if (enter_alarm && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FD_IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            det_q   <= det_d;
        end
    end

    assign fall_pending  = pend_q;
    assign fall_detected = det_q;
    assign fall_count    = cnt_q;

endmodule

// File: rtl/fall_monitor.sv
// fall_monitor: CHANNELS independent fall detectors with latched alarms
// and saturating per-lane event counters.
// Optional macro FALL_HYST_EN: adds HYST margin to the alarm release test.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sampleValid    sample strobe for all lanes
//   sensorValue    packed lane values, lane i at [i*WIDTH +: WIDTH]
//   factoryValue   packed lane thresholds, same packing
//   ack            per-lane alarm acknowledge
//   clrCount       synchronous clear of all counters
//   fallPending    per-lane partial run in progress
//   fallDetected   per-lane latched alarm
//   anyFall        OR of fallDetected
//   firstChannel   lowest lane index with an alarm, 0 when none
//   fallCount      packed per-lane counters, lane i at [i*CNT_W +: CNT_W]
module fall_monitor
    import fall_pkg::*;
#(
    parameter int WIDTH    = FD_WIDTH_DEF,
    parameter int CHANNELS = FD_CHANNELS_DEF,
    parameter int HOLD     = FD_HOLD_DEF,
    parameter int CNT_W    = FD_CNT_W_DEF,
    parameter int HYST     = FD_HYST_DEF,
    localparam int FC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sampleValid,
    input  logic [CHANNELS*WIDTH-1:0] sensorValue,
    input  logic [CHANNELS*WIDTH-1:0] factoryValue,
    input  logic [CHANNELS-1:0]       ack,
    input  logic                      clrCount,
    output logic [CHANNELS-1:0]       fallPending,
    output logic [CHANNELS-1:0]       fallDetected,
    output logic                      anyFall,
    output logic [FC_W-1:0]           firstChannel,
    output logic [CHANNELS*CNT_W-1:0] fallCount
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        fall_channel #(
            .WIDTH (WIDTH),
            .HOLD  (HOLD),
            .CNT_W (CNT_W),
            .HYST  (HYST)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .sample_valid  (sampleValid),
            .sensor        (sensorValue[i*WIDTH +: WIDTH]),
            .factory       (factoryValue[i*WIDTH +: WIDTH]),
            .ack           (ack[i]),
            .clr_count     (clrCount),
            .fall_pending  (fallPending[i]),
            .fall_detected (fallDetected[i]),
            .fall_count    (fallCount[i*CNT_W +: CNT_W])
        );
    end

    assign anyFall = |fallDetected;

    // Scan high to low so the lowest set lane is the last writer.
    always_comb begin
        firstChannel = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fallDetected[i])
                firstChannel = FC_W'(i);
        end
    end

endmodule

// File: tb/tb_fall_monitor.sv
module tb_fall_monitor;

    localparam int W  = 8;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sampleValid = 1'b0;
    logic [CH*W-1:0]   sensorValue;
    logic [CH*W-1:0]   factoryValue;
    logic [CH-1:0]     ack = '0;
    logic              clrCount = 1'b0;

    logic [CH-1:0]     fallPending, fallDetected;
    logic              anyFall;
    logic [1:0]        firstChannel;
    logic [CH*8-1:0]   fallCount;

    logic [CH-1:0]     c2_pending, c2_detected;
    logic              c2_any;
    logic [1:0]        c2_first;
    logic [CH*2-1:0]   c2_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fall_monitor dut (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid),
        .sensorValue(sensorValue), .factoryValue(factoryValue),
        .ack(ack), .clrCount(clrCount),
        .fallPending(fallPending), .fallDetected(fallDetected),
        .anyFall(anyFall), .firstChannel(firstChannel), .fallCount(fallCount)
    );

    fall_monitor #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid),
        .sensorValue(sensorValue), .factoryValue(factoryValue),
        .ack(ack), .clrCount(clrCount),
        .fallPending(c2_pending), .fallDetected(c2_detected),
        .anyFall(c2_any), .firstChannel(c2_first), .fallCount(c2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lane 0 carries v; the other lanes sit well above threshold
    function automatic logic [CH*W-1:0] lane0(input logic [7:0] v);
        return {8'd200, 8'd200, 8'd200, v};
    endfunction

    task automatic strobe_vec(input logic [CH*W-1:0] s);
        sensorValue = s;
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic strobe0(input logic [7:0] v);
        strobe_vec(lane0(v));
    endtask

    task automatic ack_vec(input logic [CH-1:0] m, input logic [CH*W-1:0] s);
        sensorValue = s;
        ack = m;
        tick();
        ack = '0;
    endtask

    task automatic alarm0();
        strobe0(8'd5); strobe0(8'd5); strobe0(8'd5);
    endtask

    initial begin
        factoryValue = {8'd7, 8'd7, 8'd7, 8'd7};
        sensorValue  = lane0(8'd200);
        #12;
        chk("reset_det", fallDetected, 0);
        chk("reset_pend", fallPending, 0);
        chk("reset_cnt", fallCount, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_any", anyFall, 0);
        chk("idle_first", firstChannel, 0);

        // threshold sweep; 7 is equality and must not qualify
        for (int v = 1; v <= 9; v++) begin
            strobe0(8'(v)); strobe0(8'(v));
            chk($sformatf("sweep%0d_pend", v), fallPending[0], (v < 7) ? 1 : 0);
            strobe0(8'(v));
            chk($sformatf("sweep%0d_det", v), fallDetected[0], (v < 7) ? 1 : 0);
            ack_vec(4'b0001, lane0(8'd9));
            chk($sformatf("sweep%0d_rel", v), fallDetected[0], 0);
        end
        chk("sweep_cnt", fallCount[7:0], 6);
        chk("sweep_c2_sat", c2_count[1:0], 3);

        // broken run
        strobe0(8'd5); chk("brk_p1", fallPending[0], 1);
        strobe0(8'd5); chk("brk_p2", fallPending[0], 1);
        strobe0(8'd9); chk("brk_p3", fallPending[0], 0);
        chk("brk_d3", fallDetected[0], 0);
        strobe0(8'd5); strobe0(8'd5);
        chk("brk_d5", fallDetected[0], 0);
        chk("brk_p5", fallPending[0], 1);
        strobe0(8'd5);
        chk("brk_d6", fallDetected[0], 1);
        chk("brk_p6", fallPending[0], 0);
        ack_vec(4'b0001, lane0(8'd9));

        // ack outside alarm does nothing
        strobe0(8'd5);
        ack_vec(4'b0001, lane0(8'd9));
        chk("ack_pend_kept", fallPending[0], 1);
        sensorValue = lane0(8'd200);
        tick(); tick();
        chk("gap_pend_kept", fallPending[0], 1);
        strobe0(8'd5);
        tick(); tick(); tick();
        chk("gap_no_alarm", fallDetected[0], 0);
        strobe0(8'd5);
        chk("gap_alarm", fallDetected[0], 1);

        // alarm ignores samples, then release test
        strobe0(8'd9);
        chk("alarm_hold", fallDetected[0], 1);
        ack_vec(4'b0001, lane0(8'd8));
`ifdef FALL_HYST_EN
        chk("hyst_no_rel8", fallDetected[0], 1);
        ack_vec(4'b0001, lane0(8'd9));
        chk("hyst_rel9", fallDetected[0], 0);
`else
        chk("rel8", fallDetected[0], 0);
`endif
        ack_vec(4'b0001, lane0(8'd6));
        chk("cnt_after_gap", fallCount[7:0], 8);

        // multi-lane
        for (int k = 0; k < 3; k++) strobe_vec({8'd5, 8'd200, 8'd5, 8'd200});
        chk("ml_det", fallDetected, 4'b1010);
        chk("ml_any", anyFall, 1);
        chk("ml_first", firstChannel, 1);
        ack_vec(4'b0010, {8'd200, 8'd200, 8'd200, 8'd200});
        chk("ml_det2", fallDetected, 4'b1000);
        chk("ml_first2", firstChannel, 3);
        chk("ml_cnt3", fallCount[31:24], 1);
        ack_vec(4'b1000, {8'd200, 8'd200, 8'd200, 8'd200});
        chk("ml_any0", anyFall, 0);
        chk("ml_first0", firstChannel, 0);

        // counters
        clrCount = 1'b1; tick(); clrCount = 1'b0;
        chk("clr_cnt", fallCount, 0);
        for (int k = 0; k < 5; k++) begin
            alarm0();
            ack_vec(4'b0001, lane0(8'd9));
        end
        chk("cnt5", fallCount[7:0], 5);
        chk("c2_sat3", c2_count[1:0], 3);
        strobe0(8'd5); strobe0(8'd5);
        clrCount = 1'b1; strobe0(8'd5); clrCount = 1'b0;
        chk("clr_wins_det", fallDetected[0], 1);
        chk("clr_wins_cnt", fallCount[7:0], 0);
        ack_vec(4'b0001, lane0(8'd9));

        // async reset mid-alarm and mid-run
        alarm0();
        ack_vec(4'b0001, lane0(8'd9));
        for (int k = 0; k < 3; k++) strobe_vec({8'd5, 8'd200, 8'd200, 8'd200});
        strobe0(8'd5);
        chk("pre_rst_pend", fallPending[0], 1);
        chk("pre_rst_det3", fallDetected[3], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pend", fallPending, 0);
        chk("rst_det", fallDetected, 0);
        chk("rst_any", anyFall, 0);
        chk("rst_first", firstChannel, 0);
        chk("rst_cnt", fallCount, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fall_monitor.md
# fall_monitor

Multi-channel, sequential successor to the single-channel combinational falling detector. Each of CHANNELS sensor lanes is compared against its own factory threshold on every sample strobe. A fall is declared only after HOLD consecutive qualifying samples, and it is then latched until acknowledged. The block sits between the sensor sampling front-end and the alarm/status logic, and keeps a saturating per-channel fall-event count.

## Interface
Parameters:
- WIDTH, 8, bit width of sensor and factory values (unsigned)
- CHANNELS, 4, number of independent lanes (≥1)
- HOLD, 3, consecutive qualifying samples needed to declare a fall (≥1)
- CNT_W, 8, width of each per-channel fall-event counter
- HYST, 2, release hysteresis margin, used only when FALL_HYST_EN is defined

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- sampleValid  in  1  new sample present on all lanes this cycle
- sensorValue  in  CHANNELS*WIDTH  packed sensor values; lane i at [i*WIDTH +: WIDTH]
- factoryValue  in  CHANNELS*WIDTH  packed per-lane thresholds, same packing as sensorValue
- ack  in  CHANNELS  per-lane alarm acknowledge
- clrCount  in  1  synchronous clear of all event counters
- fallPending  out  CHANNELS  lane has ≥1 but <HOLD consecutive qualifying samples
- fallDetected  out  CHANNELS  latched fall alarm per lane
- anyFall  out  1  OR of fallDetected
- firstChannel  out  $clog2(CHANNELS) (min 1)  lowest index with fallDetected set, 0 when none
- fallCount  out  CHANNELS*CNT_W  packed saturating event counters

## Operation
- Qualifying sample: sampleValid=1 and sensorValue[i] < factoryValue[i], unsigned compare. Equality does not qualify.
- Per-lane FSM states and transitions:
  - FD_IDLE:
    - qualifying sample → FD_PENDING with run=1.
    - If HOLD=1, a qualifying sample goes directly to FD_ALARM.
  - FD_PENDING:
    - qualifying sample → run+1; when run reaches HOLD → FD_ALARM.
    - non-qualifying valid sample → FD_IDLE with run=0.
    - cycles with sampleValid=0 leave state and run unchanged.
  - FD_ALARM:
    - samples are ignored.
    - ack[i]=1 with release condition true → FD_IDLE with run=0.
    - ack[i] with release condition false is ignored; the lane stays in FD_ALARM.
- Release condition is evaluated on the same-cycle sensorValue[i], regardless of sampleValid. Its form depends on FALL_HYST_EN (see Configuration).
- ack in FD_IDLE or FD_PENDING has no effect.
- Simultaneous ack and sampleValid in FD_ALARM: ack is evaluated and the sample is discarded.
- Run counter width is $clog2(HOLD+1).
- Outputs per state: fallPending=1 only in FD_PENDING; fallDetected=1 only in FD_ALARM.
- fallCount[i] increments by 1 on each entry into FD_ALARM and saturates at 2^CNT_W−1.
- clrCount zeroes all counters. If clrCount coincides with an increment, clear wins and the counter reads 0.
- Lanes are fully independent; no shared arbitration.

## Timing
- Reset: all FSMs go to FD_IDLE; run=0, fallPending=0, fallDetected=0, anyFall=0, firstChannel=0, fallCount=0.
  - Reset takes effect immediately on rst_n falling, including mid-run or mid-alarm.
- fallPending, fallDetected and fallCount are registered.
  - They update on the clk edge that samples the qualifying input, so they are visible in the cycle after the strobe.
- Alarm latency: fallDetected rises 1 cycle after the HOLD-th consecutive qualifying strobe.
- Release latency: fallDetected falls 1 cycle after an accepted ack.
- anyFall and firstChannel are combinational decodes of the fallDetected registers, valid in the same cycle as fallDetected.
- No backpressure: sampleValid may be asserted every cycle.

## Configuration
- FALL_HYST_EN defined:
  - Release condition is sensorValue[i] ≥ factoryValue[i] + HYST.
  - The sum is computed at WIDTH+1 bits, so an overflowing sum can never release.
- FALL_HYST_EN undefined:
  - Release condition is sensorValue[i] ≥ factoryValue[i].
  - HYST is unused.

## Structure
- Package fall_pkg holds:
  - the state enum FD_IDLE / FD_PENDING / FD_ALARM (2-bit encoding);
  - the default parameter constants.
- Sub-module fall_channel contains one lane: compare, run counter, FSM and event counter. It is instantiated CHANNELS times by generate.
- The top level holds only the unpacking of the packed buses, the anyFall OR and the firstChannel priority encoder.

## Test plan
Defaults throughout unless noted; lane 0 factoryValue=7.
- Sweep: sensorValue 1..9, each held for 3 strobes. Required: fallDetected[0]=1 after the 3rd strobe for values 1..6 (ack between steps); no alarm for 7, 8, 9.
- Broken run: sensorValue 5,5,9,5,5 on 5 strobes. Required: fallPending toggles, fallDetected stays 0. A further strobe at 5 raises fallDetected.
- Strobe gaps: 3 qualifying strobes separated by idle cycles. Required: alarm raised; gaps neither advance nor reset run.
- Ack/hysteresis: in alarm, sensorValue=8 with ack.
  - Without FALL_HYST_EN: release.
  - With FALL_HYST_EN: no release at 8; release at 9.
- Multi-lane: lanes 1 and 3 alarm together. Required: anyFall=1, firstChannel=1. After ack of lane 1 only: firstChannel=3.
- Counter and reset: CNT_W=2, 5 alarm/ack cycles. Required: fallCount[0]=3 (saturated). clrCount → 0. rst_n pulsed during FD_PENDING → all outputs 0 immediately.
